ping_pong_observer: RTL and testbench
=====================================

Name: ping_pong_observer

Overview:
- Receiving-end monitor for the parameterized ping-pong counter. It watches the counter's output stream and the same max/min bounds, and rebuilds the count direction from the values alone.
- Classifies every enabled step as a normal count, boundary turn, flip, or illegal step.
- Used in the system as a checker / direction decoder wherever the counter's value is consumed without its direction line.

Parameters:
WIDTH, 4, width of value/max/min
CNT_W, 8, width of the saturating bounce and error counters

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
sample_en  input  1  value is a new counter output this cycle; mirrors the counter's enable
value  input  WIDTH  observed counter output
max  input  WIDTH  upper bound, same signal the counter sees
min  input  WIDTH  lower bound, same signal the counter sees
direction  output  1  reconstructed direction, 1=up, 0=down
locked  output  1  1 while in TRACK
turn_pulse  output  1  one-cycle pulse: boundary turn detected
flip_pulse  output  1  one-cycle pulse: mid-range reversal detected
err_pulse  output  1  one-cycle pulse: illegal step
error  output  1  sticky error flag, cleared only by rst
bounce_count  output  CNT_W  saturating count of boundary turns
err_count  output  CNT_W  saturating count of illegal steps

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous, active-high.
- Reset values: state=IDLE, direction=1, locked=0, all pulses 0, error=0, both counters 0, prev=0.
- Output timing: all outputs are registered. Pulses assert in the cycle after the sampled edge and last exactly one cycle.
- sample_en=0: state, prev, direction and counters hold; pulses are 0.
- Range: range_ok = (max > min), compared unsigned.
- Arithmetic: all step arithmetic is in WIDTH+1 bits, so 15->0 is never treated as +1.
- Range change: if max or min differs from the value registered on the last accepted sample, the sample is accepted with no check, prev=value, and the state goes to ACQ.
- range_ok=0, any state past IDLE: the only legal sample is value==prev. Anything else is an illegal step. Direction is unchanged.

States:
- IDLE: first accepted sample -> prev=value, go to ACQ.
- ACQ (range_ok):
  - value==prev+1 -> direction=1, go to TRACK.
  - value==prev-1 -> direction=0, go to TRACK.
  - Otherwise -> illegal step, stay in ACQ.
  - No turn or flip is ever reported from ACQ.
- TRACK (range_ok), with p=prev and d=direction:
  - e_norm: if d=1: p==max ? p-1 (turn) : p+1. If d=0: p==min ? p+1 (turn) : p-1.
  - e_flip: the step opposite to e_norm. Legal only if it lies within [min,max].
  - value==e_norm -> update direction; turn_pulse and bounce_count+1 if it was a turn.
  - value==e_flip -> direction toggles, flip_pulse.
  - Otherwise -> illegal step.
- Illegal step (any state): err_pulse, error=1, err_count+1 (saturating), prev=value, go to ACQ. Also illegal: value outside [min,max] while range_ok.
- prev is updated on every accepted sample.

Boundary cases:
- max-min==1: the counter alternates; every step is a turn. e_flip is always illegal.
- rst mid-stream: returns to IDLE next edge and overrides the sample on that cycle.
- Counters hold at all-ones.

Decomposition:
- Package pp_obs_pkg: state enum {IDLE, ACQ, TRACK}; constants DIR_UP=1'b1, DIR_DOWN=1'b0.
- Sub-module ping_pong_step_predictor: combinational block taking p, d, max, min and producing e_norm, is_turn, e_flip, flip_ok.
- Top level: FSM, registers and counters.

Test Plan:
- max=15, min=0; stream 0,1,...,15,14 -> locked after 2nd sample; turn_pulse once after the 14; direction=0; bounce_count=1; error=0.
- Up-count 5,6,7 then 6 (counter flipped) -> flip_pulse one cycle; direction=0; bounce_count unchanged; no error.
- Stream 3,4,6 -> err_pulse; error=1; err_count=1; locked=0. Then 7,8 -> relocks with direction=1; error stays 1.
- While tracking, min=8, max=11; stream 8,9,10,11,10 -> no error on the range-change sample; relock; one turn at 11; bounce_count +1.
- min=15, max=0 (range_ok=0); value held at 9 for 4 cycles -> no pulses. Value changes to 10 -> err_pulse. Restore 0..15 -> reacquire.
- sample_en low for 4 cycles mid-count, then resumes with the next step -> no pulses or errors. rst pulse -> every output returns to its reset value.

Source files
------------

// File: rtl/pp_obs_pkg.sv
// Shared types and constants for the ping-pong counter observer.
// The observer FSM states and the direction encoding it reconstructs.
package pp_obs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/ping_pong_step_predictor.sv
// Predicts the counter's next value from the previous value and direction,
// plus the opposite (reversal) step and whether that reversal stays in range.
module ping_pong_step_predictor #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] p,
    input  logic             d,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] min,
    output logic [WIDTH:0]   e_norm,
    output logic             is_turn,
    output logic [WIDTH:0]   e_flip,
    output logic             flip_ok
);

    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

    logic [WIDTH:0] p_x;
    logic [WIDTH:0] max_x;
    logic [WIDTH:0] min_x;
    logic           step_up;

    assign p_x   = {1'b0, p};
    assign max_x = {1'b0, max};
    assign min_x = {1'b0, min};

    // One bit of headroom keeps 0-1 from aliasing onto a legal in-range value.
    always_comb begin
        is_turn = d ? (p == max) : (p == min);
        step_up = d ^ is_turn;
        e_norm  = step_up ? (p_x + ONE) : (p_x - ONE);
        e_flip  = step_up ? (p_x - ONE) : (p_x + ONE);
        flip_ok = (e_flip >= min_x) && (e_flip <= max_x);
    end

endmodule

// File: rtl/ping_pong_observer.sv
// Rebuilds a ping-pong counter's direction from its output values, classifying
// each sample as a normal step, boundary turn, mid-range flip or illegal step.
module ping_pong_observer
    import pp_obs_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] min,
    output logic             direction,
    output logic             locked,
    output logic             turn_pulse,
    output logic             flip_pulse,
    output logic             err_pulse,
    output logic             error,
    output logic [CNT_W-1:0] bounce_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [WIDTH:0]   ONE     = (WIDTH+1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] prev_reg, prev_next;
    logic             dir_reg, dir_next;
    logic [WIDTH-1:0] max_reg, min_reg;
    logic             turn_reg, turn_next;
    logic             flip_reg, flip_next;
    logic             err_reg, err_next;
    logic             error_reg;
    logic [CNT_W-1:0] bounce_reg, errc_reg;

    logic [WIDTH:0]   e_norm, e_flip;
    logic             is_turn, flip_ok;
    logic [WIDTH:0]   v_x, p_x;
    logic             range_ok, range_chg, in_range;

    ping_pong_step_predictor #(.WIDTH(WIDTH)) u_pred (
        .p       (prev_reg),
        .d       (dir_reg),
        .max     (max),
        .min     (min),
        .e_norm  (e_norm),
        .is_turn (is_turn),
        .e_flip  (e_flip),
        .flip_ok (flip_ok)
    );

    assign v_x       = {1'b0, value};
    assign p_x       = {1'b0, prev_reg};
    assign range_ok  = (max > min);
    assign range_chg = (max != max_reg) || (min != min_reg);
    assign in_range  = (value >= min) && (value <= max);

    always_comb begin
        state_next = state_reg;
        prev_next  = prev_reg;
        dir_next   = dir_reg;
        turn_next  = 1'b0;
        flip_next  = 1'b0;
        err_next   = 1'b0;
        if (sample_en) begin
            prev_next = value;
            if (state_reg == IDLE || range_chg) begin
                // Fresh start or new bounds: nothing to compare against yet.
                state_next = ACQ;
            end else if (!range_ok) begin
                err_next = (value != prev_reg);
            end else if (!in_range) begin
                err_next = 1'b1;
            end else if (state_reg == ACQ) begin
                if (v_x == p_x + ONE) begin
                    dir_next   = DIR_UP;
                    state_next = TRACK;
                end else if (v_x == p_x - ONE) begin
                    dir_next   = DIR_DOWN;
                    state_next = TRACK;
                end else begin
                    err_next = 1'b1;
                end
            end else begin
                if (v_x == e_norm) begin
                    dir_next  = (e_norm > p_x) ? DIR_UP : DIR_DOWN;
                    turn_next = is_turn;
                end else if (flip_ok && v_x == e_flip) begin
                    dir_next  = ~dir_reg;
                    flip_next = 1'b1;
                end else begin
                    err_next = 1'b1;
                end
            end
            if (err_next) begin
                state_next = ACQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            prev_reg   <= '0;
            dir_reg    <= DIR_UP;
            max_reg    <= '0;
            min_reg    <= '0;
            turn_reg   <= 1'b0;
            flip_reg   <= 1'b0;
            err_reg    <= 1'b0;
            error_reg  <= 1'b0;
            bounce_reg <= '0;
            errc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            prev_reg  <= prev_next;
            dir_reg   <= dir_next;
            turn_reg  <= turn_next;
            flip_reg  <= flip_next;
            err_reg   <= err_next;
            if (sample_en) begin
                max_reg <= max;
                min_reg <= min;
            end
            if (err_next) begin
                error_reg <= 1'b1;
            end
            if (turn_next && bounce_reg != '1) begin
                bounce_reg <= bounce_reg + CNT_ONE;
            end
            if (err_next && errc_reg != '1) begin
                errc_reg <= errc_reg + CNT_ONE;
            end
        end
    end

    assign direction    = dir_reg;
    assign locked       = (state_reg == TRACK);
    assign turn_pulse   = turn_reg;
    assign flip_pulse   = flip_reg;
    assign err_pulse    = err_reg;
    assign error        = error_reg;
    assign bounce_count = bounce_reg;
    assign err_count    = errc_reg;

endmodule

// File: tb/tb_ping_pong_observer.sv
// Bench for ping_pong_observer: a counter-level reference model checked every
// cycle, plus directed streams with literal expectations.
module tb_ping_pong_observer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             sample_en;
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] max;
    logic [WIDTH-1:0] min;
    logic             direction;
    logic             locked;
    logic             turn_pulse;
    logic             flip_pulse;
    logic             err_pulse;
    logic             error;
    logic [CNT_W-1:0] bounce_count;
    logic [CNT_W-1:0] err_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 0;

    ping_pong_observer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_en    (sample_en),
        .value        (value),
        .max          (max),
        .min          (min),
        .direction    (direction),
        .locked       (locked),
        .turn_pulse   (turn_pulse),
        .flip_pulse   (flip_pulse),
        .err_pulse    (err_pulse),
        .error        (error),
        .bounce_count (bounce_count),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL cyc %0d %s got %0d want %0d", cyc, name, act, req);
        end
    endtask

    // Reference model: mode 0=idle, 1=acquiring, 2=tracking, all in plain ints.
    int m_mode, m_prev, m_dir, m_max, m_min, m_bounce, m_errc;
    bit m_turn, m_flip, m_err, m_error;
    int v, mx, mn, nxt, rev;
    bit bad, bounced;

    always @(posedge clk) begin
        m_turn = 0;
        m_flip = 0;
        m_err  = 0;
        if (rst) begin
            m_mode = 0; m_prev = 0; m_dir = 1; m_max = 0; m_min = 0;
            m_bounce = 0; m_errc = 0; m_error = 0;
        end else if (sample_en) begin
            v  = int'(value);
            mx = int'(max);
            mn = int'(min);
            bad = 0;
            if (m_mode == 0 || mx != m_max || mn != m_min) begin
                m_mode = 1;
            end else if (mx <= mn) begin
                bad = (v != m_prev);
            end else if (v < mn || v > mx) begin
                bad = 1;
            end else if (m_mode == 1) begin
                if (v == m_prev + 1 || v == m_prev - 1) begin
                    m_dir  = (v > m_prev) ? 1 : 0;
                    m_mode = 2;
                end else begin
                    bad = 1;
                end
            end else begin
                // where a counter that keeps going would land, bouncing off a bound
                nxt = (m_dir == 1) ? m_prev + 1 : m_prev - 1;
                bounced = (nxt > mx || nxt < mn);
                if (bounced) nxt = 2 * m_prev - nxt;
                rev = 2 * m_prev - nxt;
                if (v == nxt) begin
                    m_dir = (nxt > m_prev) ? 1 : 0;
                    if (bounced) begin
                        m_turn = 1;
                        if (m_bounce < 255) m_bounce = m_bounce + 1;
                    end
                end else if (v == rev && rev >= mn && rev <= mx) begin
                    m_dir  = 1 - m_dir;
                    m_flip = 1;
                end else begin
                    bad = 1;
                end
            end
            if (bad) begin
                m_err = 1;
                m_error = 1;
                if (m_errc < 255) m_errc = m_errc + 1;
                m_mode = 1;
            end
            m_prev = v;
            m_max  = mx;
            m_min  = mn;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            check("direction",    int'(direction),    m_dir);
            check("locked",       int'(locked),       (m_mode == 2) ? 1 : 0);
            check("turn_pulse",   int'(turn_pulse),   int'(m_turn));
            check("flip_pulse",   int'(flip_pulse),   int'(m_flip));
            check("err_pulse",    int'(err_pulse),    int'(m_err));
            check("error",        int'(error),        int'(m_error));
            check("bounce_count", int'(bounce_count), m_bounce);
            check("err_count",    int'(err_count),    m_errc);
        end
    end

    task automatic smp(input int val);
        sample_en = 1'b1;
        value     = WIDTH'(val);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        sample_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        sample_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_direction"},  int'(direction),    1);
        check({tag, "_locked"},     int'(locked),       0);
        check({tag, "_pulses"},     int'({turn_pulse, flip_pulse, err_pulse}), 0);
        check({tag, "_error"},      int'(error),        0);
        check({tag, "_bounce"},     int'(bounce_count), 0);
        check({tag, "_errcnt"},     int'(err_count),    0);
    endtask

    initial begin
        rst = 1'b1; sample_en = 1'b0; value = '0; max = 4'd15; min = 4'd0;
        @(negedge clk);
        chk_en = 1;
        rst = 1'b0;
        check_reset_state("rst0");

        // Full sweep up then first bounce off 15
        smp(0);
        smp(1);
        check("a_locked_2nd", int'(locked), 1);
        for (int i = 2; i <= 15; i++) smp(i);
        check("a_no_turn_at_15", int'(turn_pulse), 0);
        smp(14);
        check("a_turn", int'(turn_pulse), 1);
        check("a_dir", int'(direction), 0);
        check("a_bounce", int'(bounce_count), 1);
        check("a_error", int'(error), 0);
        smp(13);
        check("a_turn_one_cycle", int'(turn_pulse), 0);

        // Mid-range reversal
        do_reset();
        smp(5); smp(6); smp(7); smp(6);
        check("b_flip", int'(flip_pulse), 1);
        check("b_dir", int'(direction), 0);
        check("b_bounce", int'(bounce_count), 0);
        check("b_error", int'(error), 0);
        idle(1);
        check("b_flip_one_cycle", int'(flip_pulse), 0);
        smp(5);

        // Skipped value, then relock
        do_reset();
        smp(3); smp(4); smp(6);
        check("c_errp", int'(err_pulse), 1);
        check("c_error", int'(error), 1);
        check("c_errcnt", int'(err_count), 1);
        check("c_locked", int'(locked), 0);
        smp(7); smp(8);
        check("c_relock", int'(locked), 1);
        check("c_dir", int'(direction), 1);
        check("c_error_sticky", int'(error), 1);

        // Range narrows while tracking
        min = 4'd8; max = 4'd11;
        smp(8);
        check("d_no_err_on_chg", int'(err_pulse), 0);
        smp(9); smp(10); smp(11); smp(10);
        check("d_turn", int'(turn_pulse), 1);
        check("d_bounce", int'(bounce_count), 1);
        check("d_errcnt", int'(err_count), 1);

        // Inverted bounds: only a held value is legal
        min = 4'd15; max = 4'd0;
        repeat (4) begin
            smp(9);
            check("e_quiet", int'({turn_pulse, flip_pulse, err_pulse}), 0);
        end
        smp(10);
        check("e_errp", int'(err_pulse), 1);
        check("e_errcnt", int'(err_count), 2);
        min = 4'd0; max = 4'd15;
        smp(10); smp(11);
        check("e_relock", int'(locked), 1);
        smp(12);

        // Enable gap mid-count
        idle(4);
        check("f_gap_quiet", int'({turn_pulse, flip_pulse, err_pulse}), 0);
        smp(13); smp(14);
        check("f_errcnt", int'(err_count), 2);
        check("f_locked", int'(locked), 1);

        // Adjacent bounds: every step is a turn
        do_reset();
        min = 4'd4; max = 4'd5;
        smp(4); smp(5); smp(4);
        check("g_turn1", int'(turn_pulse), 1);
        smp(5);
        check("g_turn2", int'(turn_pulse), 1);
        check("g_bounce", int'(bounce_count), 2);
        check("g_dir", int'(direction), 1);
        check("g_error", int'(error), 0);

        // Error counter saturation
        min = 4'd15; max = 4'd0;
        for (int i = 0; i < 270; i++) smp(i % 2);
        check("h_errcnt_sat", int'(err_count), 255);
        check("h_error", int'(error), 1);

        // Reset mid-stream overrides the sample on that edge
        rst = 1'b1; sample_en = 1'b1; value = 4'd3;
        @(negedge clk);
        rst = 1'b0; sample_en = 1'b0;
        check_reset_state("rst1");

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
